// File: rtl/ir_weight_bank.sv
`default_nettype none
// ============================================================================
//  Module   : ir_weight_bank
//  Purpose  : Double-buffered complex IR weight store with conjugate-symmetric
//             mirroring and frame-aligned bank swap.
//  Revision : 1.0
// ============================================================================
module ir_weight_bank #(
    parameter int N  = 64,
    parameter int W  = 16,
    parameter int AW = $clog2(N)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_rd_valid,
    input  logic [AW-1:0] i_rd_addr,
    output logic          o_rd_valid,
    output logic [W-1:0]  o_weights_re,
    output logic [W-1:0]  o_weights_im,
    input  logic          i_wr_valid,
    output logic          o_wr_ready,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [W-1:0]  i_wr_re,
    input  logic [W-1:0]  i_wr_im,
    input  logic          i_sym_mode,
    output logic          o_wr_err,
    input  logic          i_commit,
    input  logic          i_frame_start,
    output logic          o_commit_pending,
    output logic          o_swapped,
    output logic          o_bank_valid
);

    localparam logic [0:0]    S_IDLE   = 1'b0;
    localparam logic [0:0]    S_MIRROR = 1'b1;
    localparam logic [AW-1:0] c_half   = AW'(N / 2);
    localparam logic [AW-1:0] c_one_aw = AW'(1);
    localparam logic [W-1:0]  c_one_w  = W'(1);
    localparam logic [W-1:0]  c_min_w  = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]  c_max_w  = {1'b0, {(W-1){1'b1}}};

    // Both banks share one array; the MSB of the index selects the bank.
    logic [W-1:0]  r_mem_re [0:2*N-1];
    logic [W-1:0]  r_mem_im [0:2*N-1];

    logic [0:0]    r_state;
    logic [0:0]    w_state_nxt;
    logic          r_bank_sel;
    logic          r_pending;
    logic          r_bank_valid;
    logic          r_swapped;
    logic          r_wr_err;
    logic          r_rd_valid;
    logic [W-1:0]  r_rd_re;
    logic [W-1:0]  r_rd_im;
    logic [AW-1:0] r_mir_addr;
    logic [W-1:0]  r_mir_re;
    logic [W-1:0]  r_mir_im;
    logic          r_mir_bank;

    logic          w_wr_ready;
    logic          w_mem_we;
    logic [AW:0]   w_mem_addr;
    logic [W-1:0]  w_mem_re;
    logic [W-1:0]  w_mem_im;
    logic          w_wr_err;
    logic          w_mir_load;
    logic          w_swap;
    logic [W-1:0]  w_neg_im;
    logic [AW-1:0] w_mir_dst;

    // Negating the most negative value saturates instead of wrapping.
    assign w_neg_im  = (r_mir_im == c_min_w) ? c_max_w : (~r_mir_im + c_one_w);
    assign w_mir_dst = ~r_mir_addr + c_one_aw;
    assign w_swap    = (r_pending | i_commit) & i_frame_start & (r_state == S_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        w_wr_ready  = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = '0;
        w_mem_re    = '0;
        w_mem_im    = '0;
        w_wr_err    = 1'b0;
        w_mir_load  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_wr_ready = !r_pending;
                if (i_wr_valid && w_wr_ready) begin
                    w_mem_addr = {~r_bank_sel, i_wr_addr};
                    w_mem_re   = i_wr_re;
                    w_mem_im   = i_wr_im;
                    if (!i_sym_mode) begin
                        w_mem_we = 1'b1;
                    end else if (i_wr_addr == '0 || i_wr_addr == c_half) begin
                        w_mem_we = 1'b1;
                        w_mem_im = '0;
                    end else if (i_wr_addr < c_half) begin
                        w_mem_we    = 1'b1;
                        w_mir_load  = 1'b1;
                        w_state_nxt = S_MIRROR;
                    end else begin
                        w_wr_err = 1'b1;
                    end
                end
            end
            S_MIRROR: begin
                w_mem_we    = 1'b1;
                w_mem_addr  = {r_mir_bank, w_mir_dst};
                w_mem_re    = r_mir_re;
                w_mem_im    = w_neg_im;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (w_mem_we) begin
            r_mem_re[w_mem_addr] <= w_mem_re;
            r_mem_im[w_mem_addr] <= w_mem_im;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_bank_sel   <= 1'b0;
            r_pending    <= 1'b0;
            r_bank_valid <= 1'b0;
            r_swapped    <= 1'b0;
            r_wr_err     <= 1'b0;
            r_mir_addr   <= '0;
            r_mir_re     <= '0;
            r_mir_im     <= '0;
            r_mir_bank   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_swapped <= w_swap;
            r_wr_err  <= w_wr_err;
            if (w_swap) begin
                r_bank_sel   <= ~r_bank_sel;
                r_pending    <= 1'b0;
                r_bank_valid <= 1'b1;
            end else begin
                r_pending <= r_pending | i_commit;
            end
            // The target bank is captured so the mirror lands in the same bank
            // as its source entry even if a swap happens on the same edge.
            if (w_mir_load) begin
                r_mir_addr <= i_wr_addr;
                r_mir_re   <= i_wr_re;
                r_mir_im   <= i_wr_im;
                r_mir_bank <= ~r_bank_sel;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_valid <= 1'b0;
            r_rd_re    <= '0;
            r_rd_im    <= '0;
        end else begin
            r_rd_valid <= i_rd_valid;
            if (i_rd_valid) begin
                r_rd_re <= r_bank_valid ? r_mem_re[{r_bank_sel, i_rd_addr}] : '0;
                r_rd_im <= r_bank_valid ? r_mem_im[{r_bank_sel, i_rd_addr}] : '0;
            end
        end
    end

    assign o_rd_valid       = r_rd_valid;
    assign o_weights_re     = r_rd_re;
    assign o_weights_im     = r_rd_im;
    assign o_wr_ready       = w_wr_ready;
    assign o_wr_err         = r_wr_err;
    assign o_commit_pending = r_pending;
    assign o_swapped        = r_swapped;
    assign o_bank_valid     = r_bank_valid;

endmodule
`default_nettype wire
